// File: rtl/serial_frame_tx_if.sv
// Parallel word handshake into the serial frame transmitter.
// The producer drives data/valid; the transmitter answers with ready.
interface serial_frame_tx_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/serial_frame_tx.sv
// Serializes one parallel word per frame: start(1), data LSB first,
// optional even parity, stop(0); every bit lasts DIV clock cycles.
module serial_frame_tx #(
    parameter int WIDTH     = 8,
    parameter int DIV       = 1,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    serial_frame_tx_if.slave bus,
    output logic             out,
    output logic             busy,
    output logic             done
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [7:0]    DIV_LAST = 8'(DIV - 1);
    localparam logic [CW-1:0] BIT_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       div_q, div_d;
    logic             parity_q, parity_d;
    logic             out_q, out_d;
    logic             done_q, done_d;
    logic             tick;

    assign tick      = (div_q == 8'd0);
    assign bus.ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out       = out_q;
    assign done      = done_q;

    // NOTE: every variable gets its hold value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        div_d    = tick ? DIV_LAST : div_q - 8'd1;
        parity_d = parity_q;
        out_d    = out_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                div_d = 8'd0;
                out_d = 1'b0;
                if (bus.valid) begin
                    state_d  = START;
                    shift_d  = bus.data;
                    parity_d = ^bus.data;
                    div_d    = DIV_LAST;
                    out_d    = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    out_d   = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (cnt_q == BIT_LAST) begin
                        state_d = PARITY_EN ? PARITY : STOP;
                        out_d   = PARITY_EN ? parity_q : 1'b0;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        shift_d = shift_q >> 1;
                        out_d   = shift_d[0];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    out_d   = 1'b0;
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                    div_d   = 8'd0;
                    out_d   = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                div_d   = 8'd0;
                out_d   = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them
    // update together from values sampled before the edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            div_q    <= 8'd0;
            parity_q <= 1'b0;
            out_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            parity_q <= parity_d;
            out_q    <= out_d;
            done_q   <= done_d;
        end
    end
endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench: three transmitter configurations checked against a
// frame model built directly from the line-format rules.
module tb_serial_frame_tx;
    typedef bit bitq_t[$];

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    int          total = 0;
    int          bad   = 0;
    logic [31:0] data_v [3];
    logic [2:0]  valid_v;
    logic [2:0]  out_w, busy_w, done_w, ready_w;

    always #5 clock = ~clock;

    // sel 0: WIDTH=8 DIV=1 parity; sel 1: WIDTH=8 DIV=3 parity; sel 2: WIDTH=4 DIV=1 no parity
    serial_frame_tx_if #(.WIDTH(8)) if_a ();
    serial_frame_tx_if #(.WIDTH(8)) if_b ();
    serial_frame_tx_if #(.WIDTH(4)) if_c ();

    assign if_a.data  = data_v[0][7:0];
    assign if_b.data  = data_v[1][7:0];
    assign if_c.data  = data_v[2][3:0];
    assign if_a.valid = valid_v[0];
    assign if_b.valid = valid_v[1];
    assign if_c.valid = valid_v[2];
    assign ready_w    = {if_c.ready, if_b.ready, if_a.ready};

    serial_frame_tx #(.WIDTH(8), .DIV(1), .PARITY_EN(1'b1)) dut_a (
        .clock(clock), .reset(reset), .bus(if_a),
        .out(out_w[0]), .busy(busy_w[0]), .done(done_w[0])
    );
    serial_frame_tx #(.WIDTH(8), .DIV(3), .PARITY_EN(1'b1)) dut_b (
        .clock(clock), .reset(reset), .bus(if_b),
        .out(out_w[1]), .busy(busy_w[1]), .done(done_w[1])
    );
    serial_frame_tx #(.WIDTH(4), .DIV(1), .PARITY_EN(1'b0)) dut_c (
        .clock(clock), .reset(reset), .bus(if_c),
        .out(out_w[2]), .busy(busy_w[2]), .done(done_w[2])
    );

    function automatic int width_of(input int sel);
        return (sel == 2) ? 4 : 8;
    endfunction

    function automatic int div_of(input int sel);
        return (sel == 1) ? 3 : 1;
    endfunction

    function automatic bit par_of(input int sel);
        return sel != 2;
    endfunction

    // Expected line level for every cycle of one frame, in order.
    function automatic bitq_t frame_bits(input logic [31:0] word, input int sel);
        bitq_t q;
        int    ones = 0;
        int    div  = div_of(sel);
        repeat (div) q.push_back(1'b1);
        for (int i = 0; i < width_of(sel); i++) begin
            repeat (div) q.push_back(word[i]);
            if (word[i]) ones++;
        end
        if (par_of(sel)) repeat (div) q.push_back(bit'(ones % 2));
        repeat (div) q.push_back(1'b0);
        return q;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input int sel, input string tag);
        check($sformatf("%s out s%0d", tag, sel), 32'(out_w[sel]), 32'd0);
        check($sformatf("%s ready s%0d", tag, sel), 32'(ready_w[sel]), 32'd1);
        check($sformatf("%s busy s%0d", tag, sel), 32'(busy_w[sel]), 32'd0);
        check($sformatf("%s done s%0d", tag, sel), 32'(done_w[sel]), 32'd0);
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the first start-bit cycle.
    task automatic send(input int sel, input logic [31:0] word, input bit hold);
        data_v[sel]  = word;
        valid_v[sel] = 1'b1;
        check($sformatf("ready before accept s%0d", sel), 32'(ready_w[sel]), 32'd1);
        @(posedge clock);
        @(negedge clock);
        if (!hold) valid_v[sel] = 1'b0;
    endtask

    // Checks every frame cycle, then the done cycle; returns at the done-cycle negedge.
    task automatic expect_frame(input int sel, input logic [31:0] word);
        bitq_t q = frame_bits(word, sel);
        foreach (q[i]) begin
            check($sformatf("out s%0d w%0h c%0d", sel, word, i), 32'(out_w[sel]), 32'(q[i]));
            check($sformatf("busy s%0d c%0d", sel, i), 32'(busy_w[sel]), 32'd1);
            check($sformatf("done early s%0d c%0d", sel, i), 32'(done_w[sel]), 32'd0);
            @(negedge clock);
        end
        check($sformatf("done pulse s%0d", sel), 32'(done_w[sel]), 32'd1);
        check($sformatf("ready at done s%0d", sel), 32'(ready_w[sel]), 32'd1);
        check($sformatf("out at done s%0d", sel), 32'(out_w[sel]), 32'd0);
    endtask

    task automatic one_frame(input int sel, input logic [31:0] word);
        send(sel, word, 1'b0);
        data_v[sel] = $urandom;
        expect_frame(sel, word);
        @(negedge clock);
        check_idle(sel, "after done");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        valid_v = 3'b000;
        for (int s = 0; s < 3; s++) data_v[s] = 32'd0;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check_idle(0, "in reset");
        reset = 1'b1;

        repeat (20) begin
            @(negedge clock);
            for (int s = 0; s < 3; s++) check_idle(s, "post reset");
        end

        one_frame(0, 32'hA5);
        one_frame(1, 32'h07);
        one_frame(2, 32'h9);

        // Back-to-back: valid held, second word accepted in the done cycle.
        send(0, 32'h01, 1'b1);
        data_v[0] = 32'h80;
        expect_frame(0, 32'h01);
        @(negedge clock);
        valid_v[0] = 1'b0;
        expect_frame(0, 32'h80);
        @(negedge clock);
        check_idle(0, "after pair");

        // Asynchronous reset in the middle of data bit 4.
        send(0, 32'h3C, 1'b0);
        repeat (5) @(negedge clock);
        check("busy before abort", 32'(busy_w[0]), 32'd1);
        reset = 1'b0;
        #1;
        check_idle(0, "abort");
        repeat (3) begin
            @(negedge clock);
            check_idle(0, "held reset");
        end
        reset = 1'b1;
        repeat (2) begin
            @(negedge clock);
            check_idle(0, "after abort");
        end
        one_frame(0, 32'hFF);

        // Random words and idle gaps on every configuration.
        for (int k = 0; k < 12; k++) begin
            int sel = k % 3;
            repeat ($urandom_range(0, 3)) begin
                @(negedge clock);
                check_idle(sel, "gap");
            end
            one_frame(sel, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Transmit side of the single-wire serial bit stream consumed by the team's sequence-detector FSMs.
- Accepts a parallel word over a valid/ready handshake and serializes it onto one output line as a framed stream: start bit, data (LSB first), optional even parity, stop bit.
- Bit period is programmable in clock cycles.
- Sits between a producer (register file / test sequencer) and any serial-input FSM block.

Parameters:
WIDTH, 8, number of data bits per frame (1..32)
DIV, 1, clock cycles per serial bit (1..255)
PARITY_EN, 1, 1 = append even-parity bit after data; 0 = no parity bit

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  asynchronous, active-low reset
data  input  WIDTH  word to transmit, sampled on accept
valid  input  1  producer has a word on data
ready  output  1  block can accept a word this cycle
out  output  1  serial line
busy  output  1  frame in progress (any state other than IDLE)
done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; out=0; busy=0; done=0; ready=1; shift register, bit counter and divider cleared.
  - Reset asserted mid-frame aborts the frame immediately, with no stop bit and no done pulse.
- Line levels: idle level 0, start bit 1, stop bit 0.
- Handshake:
  - ready = (state==IDLE), combinational from state only; it does not depend on valid.
  - Accept occurs on a posedge with valid=1 and ready=1: data is latched into the shift register and state goes to START.
  - valid while not ready is ignored; the producer holds it.
  - data may change freely after accept.
- States: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
  - Each of START, each DATA bit, PARITY and STOP lasts exactly DIV cycles, timed by a divider counter that counts DIV-1 down to 0.
  - The state/bit advances on the cycle the divider is 0.
- out is registered and follows the current state:
  - START: 1.
  - DATA: shift_reg[0]; shift right at each bit boundary; bit counter runs 0..WIDTH-1.
  - PARITY: XOR of all WIDTH latched data bits (even parity: total ones in data+parity is even).
  - STOP: 0.
  - IDLE: 0.
- Timing and latency:
  - First start-bit cycle on out is the cycle after accept.
  - Frame length = DIV*(WIDTH+2+PARITY_EN) cycles. Default: 11 cycles.
- done:
  - Asserted for exactly one cycle, the first cycle in IDLE after STOP completes. ready is also 1 in that cycle.
  - If valid=1 in that cycle, the next frame is accepted there, so the minimum inter-frame gap is one idle cycle.
  - done=0 in all other cycles.
- busy = !ready.
- Parity is computed on the latched word, not the live data input.
- DIV=1 is legal: one cycle per bit and no divider wait.

Test Plan:
1. Reset release, valid=0 for 20 cycles -> out=0, ready=1, busy=0, done=0 throughout.
2. WIDTH=8, DIV=1, PARITY_EN=1, accept data=8'hA5 at cycle T -> out from T+1 = 1,1,0,1,0,0,1,0,1,0,0. That is start, LSB-first 10100101, parity 0, stop. done pulses at T+12, ready returns at T+12.
3. Same setup, data=8'h07, DIV=3 -> each bit held exactly 3 cycles; parity bit=1; frame occupies 33 cycles; done at accept+34.
4. valid held high with 8'h01 then 8'h80 -> second accept occurs in the done cycle; exactly one idle 0 cycle between the two frames; no word lost or duplicated.
5. Reset asserted during DATA bit 4 of a frame -> out=0, busy=0 in the same cycle (asynchronous); no done pulse. After release, a new frame with 8'hFF transmits correctly: parity 0, eight 1 data bits.
6. PARITY_EN=0, WIDTH=4, data=4'b1001 -> out = 1,1,0,0,1,0; done at accept+7; data changed to 4'b0110 right after accept has no effect on out.
